// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared encodings for the EX stage with RV32M multiply/divide
package exec_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RV32M unit: operand latches, fixed-latency multiply, radix-2 divider
module muldiv_unit import exec_pkg::*; #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_CYCLES  = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int MAXN = (MUL_LATENCY > DIV_CYCLES) ? MUL_LATENCY : DIV_CYCLES;
    localparam int CW   = $clog2(MAXN + 1);

    md_state_t       state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, rem_q, quo_q, dvs_q;
    logic            go;

    assign go   = start & ~flush & (state == IDLE);
    assign busy = go | (state == BUSY);
    assign done = (state == DONE);

    // DIV/REM have funct3[0]=0; unsigned variants have it set
    logic            sgn_in, sgn_q;
    logic [XLEN-1:0] a_mag, b_mag;
    assign sgn_in = ~op[0];
    assign sgn_q  = ~op_q[0];
    assign a_mag  = (sgn_in & a[XLEN-1]) ? -a : a;
    assign b_mag  = (sgn_in & b[XLEN-1]) ? -b : b;

    logic [XLEN:0]   rem_sh;
    logic            q_bit;
    logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix;
    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign q_bit  = (rem_sh >= {1'b0, dvs_q});
    assign rem_nx = q_bit ? XLEN'(rem_sh - {1'b0, dvs_q}) : rem_sh[XLEN-1:0];
    assign quo_nx = {quo_q[XLEN-2:0], q_bit};
    // -2^(XLEN-1)/-1 falls out naturally: magnitude 2^(XLEN-1), positive sign, remainder 0
    assign q_fix  = (sgn_q & (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_nx : quo_nx;
    assign r_fix  = (sgn_q & a_q[XLEN-1]) ? -rem_nx : rem_nx;

    logic [2*XLEN-1:0] ma, mb, prod;
    assign ma   = {{XLEN{(op_q != MD_MULHU) & a_q[XLEN-1]}}, a_q};
    assign mb   = {{XLEN{((op_q == MD_MUL) | (op_q == MD_MULH)) & b_q[XLEN-1]}}, b_q};
    assign prod = ma * mb;

    logic [XLEN-1:0] md_res;
    always_comb begin
        md_res = '0;
        case (op_q)
            MD_MUL:                       md_res = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: md_res = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              md_res = (b_q == '0) ? '1 : q_fix;
            default:                      md_res = (b_q == '0) ? a_q : r_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    op_q  <= op;
                    a_q   <= a;
                    b_q   <= b;
                    rem_q <= '0;
                    quo_q <= a_mag;
                    dvs_q <= b_mag;
                    cnt   <= op[2] ? CW'(DIV_CYCLES - 1) : CW'(MUL_LATENCY - 1);
                    state <= BUSY;
                end
                BUSY: if (flush) begin
                    state <= IDLE;
                end else begin
                    if (op_q[2]) begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                    end
                    if (cnt == '0) begin
                        result <= md_res;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/execute_stage_md.sv
// rtl/execute_stage_md.sv - EX stage: forwarding, ALU, branch/jump resolution, RV32M stall handshake
module execute_stage_md import exec_pkg::*; #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_CYCLES  = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            validE,
    input  logic [XLEN-1:0] pcE,
    input  logic [XLEN-1:0] rd1E,
    input  logic [XLEN-1:0] rd2E,
    input  logic [XLEN-1:0] extImmE,
    input  logic [3:0]      aluControlE,
    input  logic            aluSrcE,
    input  logic            branchE,
    input  logic [2:0]      branchF3E,
    input  logic            jumpE,
    input  logic            jalrE,
    input  logic            mdE,
    input  logic [2:0]      mdF3E,
    input  logic [1:0]      forwardAE,
    input  logic [1:0]      forwardBE,
    input  logic [XLEN-1:0] aluResultM,
    input  logic [XLEN-1:0] resultW,
    input  logic            flushE,
    output logic [XLEN-1:0] resultE,
    output logic [XLEN-1:0] writeDataE,
    output logic [XLEN-1:0] targetE,
    output logic            pcSrcE,
    output logic            stallE
);

    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0] srcA, tmpB, srcB, alu_out, md_result;
    logic [SW-1:0]   shamt;
    logic            br_taken, md_busy, md_done;

    assign srcA = (forwardAE == FWD_MEM) ? aluResultM : (forwardAE == FWD_WB) ? resultW : rd1E;
    assign tmpB = (forwardBE == FWD_MEM) ? aluResultM : (forwardBE == FWD_WB) ? resultW : rd2E;
    assign srcB = aluSrcE ? extImmE : tmpB;
    assign writeDataE = tmpB;
    assign shamt = srcB[SW-1:0];

    always_comb begin
        alu_out = '0;
        case (aluControlE)
            ALU_ADD:  alu_out = srcA + srcB;
            ALU_SUB:  alu_out = srcA - srcB;
            ALU_AND:  alu_out = srcA & srcB;
            ALU_OR:   alu_out = srcA | srcB;
            ALU_XOR:  alu_out = srcA ^ srcB;
            ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(srcA) < $signed(srcB)};
            ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, srcA < srcB};
            ALU_SLL:  alu_out = srcA << shamt;
            ALU_SRL:  alu_out = srcA >> shamt;
            ALU_SRA:  alu_out = $signed(srcA) >>> shamt;
            default:  alu_out = '0;
        endcase
    end

    // Compare on the forwarded register operands, never on the immediate
    always_comb begin
        br_taken = 1'b0;
        case (branchF3E)
            BR_BEQ:  br_taken = (srcA == tmpB);
            BR_BNE:  br_taken = (srcA != tmpB);
            BR_BLT:  br_taken = ($signed(srcA) <  $signed(tmpB));
            BR_BGE:  br_taken = ($signed(srcA) >= $signed(tmpB));
            BR_BLTU: br_taken = (srcA <  tmpB);
            BR_BGEU: br_taken = (srcA >= tmpB);
            default: br_taken = 1'b0;
        endcase
    end

    assign targetE = (jumpE & jalrE) ? ((srcA + extImmE) & {{(XLEN-1){1'b1}}, 1'b0})
                                     : (pcE + extImmE);
    assign pcSrcE  = validE & ~flushE & ~mdE & (jumpE | (branchE & br_taken));

    muldiv_unit #(
        .XLEN        (XLEN),
        .MUL_LATENCY (MUL_LATENCY),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (validE & mdE & ~flushE),
        .flush  (flushE),
        .op     (mdF3E),
        .a      (srcA),
        .b      (tmpB),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    assign resultE = md_done ? md_result : alu_out;
    assign stallE  = md_busy;

endmodule

// File: doc/execute_stage_md.md
Name: execute_stage_md

Overview:
Parametrised successor to the single-cycle EX stage.
- Keeps the 3-way forwarding muxes, the ALUSrc mux and the ALU.
- Adds full RV32I branch resolution on all six funct3 conditions, plus JAL/JALR target generation.
- Adds a multi-cycle RV32M multiply/divide path that stalls the front end through a hazard-unit handshake.
- Sits between the ID/EX and EX/MEM pipeline registers.

Parameters:
XLEN, 32, datapath width.
MUL_LATENCY, 2, busy cycles for MUL/MULH/MULHSU/MULHU (≥1).
DIV_CYCLES, XLEN, busy cycles for DIV/DIVU/REM/REMU; radix-2 iterative, one quotient bit per cycle.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
validE  in  1  EX holds a real instruction (not a bubble)
pcE  in  XLEN  PC of the EX instruction
rd1E, rd2E  in  XLEN  register-file operands
extImmE  in  XLEN  sign-extended immediate
aluControlE  in  4  ALU op (same encoding as the existing ALU)
aluSrcE  in  1  1 = immediate drives ALU operand B
branchE  in  1  conditional branch
branchF3E  in  3  branch condition (funct3)
jumpE  in  1  JAL or JALR
jalrE  in  1  JALR (valid only with jumpE)
mdE  in  1  M-extension op
mdF3E  in  3  M-extension funct3
forwardAE, forwardBE  in  2  00 = reg, 10 = MEM, 01 = WB, 11 = reg
aluResultM  in  XLEN  MEM-stage forward value
resultW  in  XLEN  WB-stage forward value
flushE  in  1  kill the EX instruction (branch mispredict / exception)
resultE  out  XLEN  ALU result, or M-extension result when complete
writeDataE  out  XLEN  forwarded rs2 (store data)
targetE  out  XLEN  branch/jump target
pcSrcE  out  1  redirect fetch
stallE  out  1  freeze F/D/E; bubble into M

Behaviour:
- srcA = fwd(rd1E, forwardAE). tmpB = fwd(rd2E, forwardBE). writeDataE = tmpB. ALU operand B = aluSrcE ? extImmE : tmpB.
- Branch compare is done on srcA vs tmpB (not through the ALU):
  - BEQ 000, BNE 001
  - BLT 100, BGE 101 (signed)
  - BLTU 110, BGEU 111 (unsigned)
  - funct3 010/011: not taken.
- targetE:
  - JALR: (srcA + extImmE) with bit0 cleared
  - otherwise: pcE + extImmE
  - all sums mod 2^XLEN.
- pcSrcE = validE & ~flushE & (jumpE | (branchE & cond)).
- If mdE=1, pcSrcE=0 and the branch decode is ignored.
- Non-md instructions:
  - combinational, zero latency
  - stallE = 0
  - resultE = ALU output.
- MD FSM states: IDLE, BUSY, DONE.
  - start = validE & mdE & ~flushE & (state==IDLE).
  - On start at cycle T:
    - latch srcA and tmpB (forward sources change while the pipeline is frozen)
    - latch mdF3E
    - cnt ← N−1, where N = MUL_LATENCY or DIV_CYCLES
    - state → BUSY.
  - BUSY: cnt decrements each cycle; at cnt==0 the result register is loaded and state → DONE (cycle T+N).
  - DONE (cycle T+N+1): resultE = result register, stallE = 0, state → IDLE at the next edge.
- stallE = start | (state==BUSY). Total stall is N+1 cycles; the instruction leaves EX at T+N+1.
- Division corner cases are RISC-V defined; latency stays fixed.
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend; remainder = 0.
- MULH, MULHSU, MULHU return the upper XLEN bits of the 2·XLEN product. MUL returns the lower XLEN bits.
- flushE during BUSY or DONE: state → IDLE at the next edge; result discarded; stallE = 0 from the following cycle.
- flushE on the same cycle as a would-be start: no start, and stallE = 0.
- rst (synchronous) mid-operation: state = IDLE, cnt = 0, result register = 0, latched operands = 0. stallE = 0 in the cycle after the reset edge.
- Outputs carry no other registers.

Decomposition:
- exec_pkg holds:
  - branch funct3 constants
  - M funct3 constants (MUL 000 … REMU 111)
  - md_state_t enum {IDLE, BUSY, DONE}
  - forward-select constants.
- One sub-module, muldiv_unit, owns the FSM, counter, operand latches, shift-subtract divider, multiplier and stall logic. It exposes start, flush, op, a, b, busy, done and result.
- The top level keeps the forwarding muxes, ALU, branch comparator and target adder.

Test Plan:
- BLT, srcA = −1 (0xFFFFFFFF), srcB = 1, pcE = 0x100, imm = 0x20 → pcSrcE = 1, targetE = 0x120. Same operands with BLTU → pcSrcE = 0.
- JALR, forwardAE = 10, aluResultM = 0x2003, imm = 4 → targetE = 0x2006, pcSrcE = 1, stallE = 0.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF with MUL_LATENCY = 2 → stallE high for 3 cycles; DONE cycle resultE = 0xFFFFFFFE.
- Change aluResultM mid-BUSY → result unaffected.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 after 33 stall cycles. REMU 7 / 0 → 7.
- DIVU 100 / 7 → 14 in the DONE cycle, and the next instruction (ADD) is not stalled.
- flushE at BUSY cycle 5 of a DIV → stallE = 0 from the next cycle.
- A new MUL issued immediately after the flush starts cleanly with full latency.
- rst asserted mid-MUL → next cycle state IDLE and stallE = 0. A following ADD 3 + 4 gives resultE = 7.
